// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: response owner
// encoding, default widths and the starvation-guard default limit.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  // Saturating increment so the 4-bit guard counter can never wrap to 0.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the load/store stage, the arbiter and
// the single-ported memory. slave = arbiter view, master = CPU/memory view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  // Fetch requester
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_valid_o;
  logic [DATA_W-1:0] if_rdata_o;

  // Data requester
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_gnt_o;
  logic              dm_valid_o;
  logic [DATA_W-1:0] dm_rdata_o;

  // Memory port
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_gnt_o, if_valid_o, if_rdata_o,
    output dm_gnt_o, dm_valid_o, dm_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_gnt_o, if_valid_o, if_rdata_o,
    input  dm_gnt_o, dm_valid_o, dm_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Fetch starvation guard: counts data grants won while a fetch waits and
// raises force_if once STARVE_MAX such grants have gone by.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req,
  input  logic if_gnt,
  input  logic dm_gnt,
  output logic force_if
);

  logic [3:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (if_gnt || !if_req) begin
      cnt <= '0;
    end else if (dm_gnt) begin
      cnt <= sat_inc4(cnt);
    end
  end

  assign force_if = (cnt == 4'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with
// one-cycle response routing. Optional fetch starvation guard: ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
  end

  logic              force_if;
  logic              if_gnt;
  logic              dm_gnt;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  owner_e            resp_owner;
  logic              resp_rd;
  logic              if_valid;
  logic              dm_valid;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .if_req  (bus.if_req_i),
    .if_gnt  (if_gnt),
    .dm_gnt  (dm_gnt),
    .force_if(force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // Data wins unless the guard is forcing a waiting fetch through.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (bus.dm_req_i && !(bus.if_req_i && force_if)) begin
      dm_gnt = 1'b1;
    end else if (bus.if_req_i) begin
      if_gnt = 1'b1;
    end
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (dm_gnt) begin
      addr_mux  = bus.dm_addr_i;
      wdata_mux = bus.dm_wdata_i;
    end else if (if_gnt) begin
      addr_mux  = bus.if_addr_i;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.dm_gnt_o    = dm_gnt;
  assign bus.mem_en_o    = if_gnt | dm_gnt;
  assign bus.mem_we_o    = dm_gnt & bus.dm_we_i;
  assign bus.mem_addr_o  = addr_mux;
  assign bus.mem_wdata_o = wdata_mux;

  // Grants taken while in reset leave no response behind.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_owner <= OWN_NONE;
      resp_rd    <= 1'b0;
    end else begin
      if (dm_gnt) begin
        resp_owner <= OWN_DM;
      end else if (if_gnt) begin
        resp_owner <= OWN_IF;
      end else begin
        resp_owner <= OWN_NONE;
      end
      resp_rd <= if_gnt | (dm_gnt & ~bus.dm_we_i);
    end
  end

  assign if_valid = (resp_owner == OWN_IF);
  assign dm_valid = (resp_owner == OWN_DM);

  assign bus.if_valid_o = if_valid;
  assign bus.dm_valid_o = dm_valid;
  assign bus.if_rdata_o = (if_valid && resp_rd) ? bus.mem_rdata_i : '0;
  assign bus.dm_rdata_o = (dm_valid && resp_rd) ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand sequences
// for contention and reset, responses tracked through a scoreboard queue.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;
  localparam logic [31:0] MEM_KEY = 32'h2002001A;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SM)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  // Memory model: read data is addr ^ MEM_KEY, one cycle after the read.
  logic [31:0] mem_q;
  always_ff @(posedge clk_i) begin
    if (bus.mem_en_o && !bus.mem_we_o) mem_q <= bus.mem_addr_o ^ MEM_KEY;
  end
  assign bus.mem_rdata_i = mem_q;

  typedef struct packed {
    logic [1:0]  own;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        we;
    logic [31:0] da;
    logic [31:0] wd;
    logic        eig;
    logic        edg;
  } vec_t;

  resp_t sbq[$];
  vec_t  vt[10];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle: drive, check this cycle's grant/mem outputs and last cycle's response.
  task automatic apply(input string tag, input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic we, input logic [31:0] da, input logic [31:0] wd,
                       input logic eig, input logic edg, input logic cg);
    resp_t e;
    resp_t n;
    @(negedge clk_i);
    rst_i          = r;
    bus.if_req_i   = ir;
    bus.if_addr_i  = ia;
    bus.dm_req_i   = dr;
    bus.dm_we_i    = we;
    bus.dm_addr_i  = da;
    bus.dm_wdata_i = wd;
    #1;
    e = '0;
    if (sbq.size() > 0) e = sbq.pop_front();
    chk({tag, ".if_valid"}, 32'(bus.if_valid_o), 32'(e.own == 2'd1));
    chk({tag, ".dm_valid"}, 32'(bus.dm_valid_o), 32'(e.own == 2'd2));
    chk({tag, ".if_rdata"}, bus.if_rdata_o, (e.own == 2'd1) ? e.data : 32'h0);
    chk({tag, ".dm_rdata"}, bus.dm_rdata_o, (e.own == 2'd2) ? e.data : 32'h0);
    if (cg) begin
      chk({tag, ".if_gnt"}, 32'(bus.if_gnt_o), 32'(eig));
      chk({tag, ".dm_gnt"}, 32'(bus.dm_gnt_o), 32'(edg));
      chk({tag, ".mem_en"}, 32'(bus.mem_en_o), 32'(eig | edg));
      chk({tag, ".mem_we"}, 32'(bus.mem_we_o), 32'(edg & we));
      if (edg) begin
        chk({tag, ".mem_addr"}, bus.mem_addr_o, da);
        chk({tag, ".mem_wdata"}, bus.mem_wdata_o, wd);
      end else if (eig) begin
        chk({tag, ".mem_addr"}, bus.mem_addr_o, ia);
      end
    end
    n = '0;
    if (!r && edg) begin
      n.own  = 2'd2;
      n.data = we ? 32'h0 : (da ^ MEM_KEY);
    end else if (!r && eig) begin
      n.own  = 2'd1;
      n.data = ia ^ MEM_KEY;
    end
    sbq.push_back(n);
  endtask

  task automatic do_reset();
    sbq.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    bus.if_req_i = 1'b0;
    bus.dm_req_i = 1'b0;
    apply("reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic ig;
    rst_i          = 1'b1;
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_addr_i  = '0;
    bus.dm_wdata_i = '0;

    vt[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0};
    vt[1] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0};
    vt[2] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'h5,        1'b0, 1'b1};
    vt[3] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0};
    vt[4] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0};
    vt[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h80, 32'h0,        1'b0, 1'b1};
    vt[6] = '{1'b1, 32'h24, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0};
    vt[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h84, 32'hDEADBEEF, 1'b0, 1'b1};
    vt[8] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h88, 32'h0,        1'b0, 1'b1};
    vt[9] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      apply($sformatf("vec%0d", i), 1'b0, vt[i].ir, vt[i].ia, vt[i].dr, vt[i].we,
            vt[i].da, vt[i].wd, vt[i].eig, vt[i].edg, 1'b1);
    end

    // Sustained contention: data priority, with a fetch every 5th cycle under the guard.
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      ig = (i % 5 == 4);
`else
      ig = 1'b0;
`endif
      apply($sformatf("cont%0d", i), 1'b0, 1'b1, 32'h100, 1'b1, 1'b0,
            32'h200 + 32'(i * 4), 32'h0, ig, ~ig, 1'b1);
    end
    apply("cont_idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Partial starvation count, then reset with a read granted in the same cycle.
    apply("pre0", 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b1, 1'b1);
    apply("pre1", 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h404, 32'h0, 1'b0, 1'b1, 1'b1);
    apply("rst_mid", 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h408, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      ig = (i == 4);
`else
      ig = 1'b0;
`endif
      apply($sformatf("post%0d", i), 1'b0, 1'b1, 32'h300, 1'b1, 1'b0,
            32'h500 + 32'(i * 4), 32'h0, ig, ~ig, 1'b1);
    end
    apply("post_idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Read granted while reset is high, then an idle cycle: everything must read 0.
    apply("rd_gnt", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 1'b0, 1'b1, 1'b1);
    apply("rd_rst", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h604, 32'h0, 1'b0, 1'b0, 1'b0);
    apply("after_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    apply("drain", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified memory between the CPU's instruction-fetch stage and its load/store stage, so the multi-cycle variant of the single-cycle CPU can run from one memory array. Each cycle it grants at most one requester and drives the memory port. It then routes the read data or write acknowledge back to the granted requester one cycle later. Data accesses have priority, and an optional starvation guard bounds how long a fetch can wait.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- STARVE_MAX, 4, consecutive data grants tolerated while a fetch waits (guard only); legal range 1..15

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- if_req_i  in  1  fetch request, held until granted
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch granted this cycle
- if_valid_o  out  1  fetch data valid
- if_rdata_o  out  DATA_W  fetch data
- dm_req_i  in  1  data request, held until granted
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_gnt_o  out  1  data granted this cycle
- dm_valid_o  out  1  read data valid / write acknowledged
- dm_rdata_o  out  DATA_W  read data
- mem_en_o  out  1  memory access this cycle
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid the cycle after a read

## Operation
- Grant decision is combinational from the requests and the registered state.
  - Only dm_req_i: grant data.
  - Only if_req_i: grant fetch.
  - Both: grant data, unless the starvation guard forces fetch.
  - Neither: mem_en_o = 0 and no grant.
- mem_* outputs are muxed from the granted requester. mem_we_o = dm_we_i only on a data grant; it is 0 on a fetch grant and when idle.
- Response state:
  - resp_owner: NONE, IF or DM.
  - resp_rd: 1 for a read, 0 for a write.
  - Both are registered each cycle from the grant.
- Cycle after a grant:
  - The owner's valid_o pulses for one cycle.
  - rdata_o carries mem_rdata_i on reads.
  - rdata_o is 0 on writes and when not valid.
- Requesters must hold req, addr, we and wdata stable until they see gnt. Deasserting req before gnt is legal and simply withdraws the request.
- Back-to-back grants every cycle are supported, with no bubble.
- Reset values:
  - All gnt_o and valid_o outputs are 0.
  - All rdata_o outputs are 0.
  - mem_en_o and mem_we_o are 0.
  - resp_owner is NONE.
  - The starvation counter is 0.
- A response pending when rst_i asserts is discarded. No valid_o pulses in the cycle after reset.

## Timing
- Request seen in cycle T with a grant: gnt_o and mem_* are asserted in T.
- valid_o and rdata_o follow at T+1, so latency is 1 cycle.
- A request waiting behind the other requester keeps gnt_o low. It is served the first cycle it wins.
- The two valid outputs are never both high. The two gnt outputs are never both high.
- A grant in T while rst_i is high in T produces no response at T+1.

## Configuration
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter increments on every data grant made while if_req_i = 1.
  - It clears on any fetch grant, and in any cycle with if_req_i = 0.
  - When the counter equals STARVE_MAX and both requesters are active, fetch is granted. That grant clears the counter.
- Undefined:
  - Strict data priority.
  - No counter is instantiated. STARVE_MAX is ignored.

## Structure
- Shared package mem_arb_pkg holds:
  - the owner enum (OWN_NONE, OWN_IF, OWN_DM);
  - the ADDR_W/DATA_W defaults;
  - the STARVE_MAX default.
- One sub-module, arb_starve_ctr, contains the guard counter and its force-fetch flag. It is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Fetch only: if_req = 1, addr 0x10, mem returns 0x2002000A → if_gnt = 1 in T, if_valid = 1 with if_rdata = 0x2002000A at T+1, dm_valid = 0.
- Data write: dm_req = 1, we = 1, addr 0x40, wdata 0x5 → mem_we = 1, mem_addr = 0x40, mem_wdata = 0x5 in T, dm_valid = 1 and dm_rdata = 0 at T+1.
- Contention with the guard undefined: both requesting for 6 cycles → dm_gnt for all 6 cycles, if_gnt = 0 throughout.
- Contention with the guard defined, STARVE_MAX = 4: both requesting → 4 data grants, then 1 fetch grant, then the data grant pattern repeats.
- Back-to-back: alternating single requests over 4 cycles → each valid pulse at the next cycle with the matching data, no idle gaps.
- Reset mid-operation: grant a read in T and assert rst_i in T → no valid at T+1, all outputs 0, counter 0.
